// File: rtl/xocc_cmd_fifo.sv
// ---------------------------------------------------------------------------
// xocc_cmd_fifo
//   Show-ahead (first-word-fall-through) synchronous FIFO for XOCC
//   command/response words. The head entry sits on rd_data whenever the FIFO
//   is not empty, so a consumer samples rd_data and pulses rd_en to retire it.
//
// Parameters
//   DATA_WIDTH   word width (matches bridge CMD_WIDTH/RSP_WIDTH)
//   ADDR_WIDTH   log2(depth), legal 1..8; DEPTH = 2**ADDR_WIDTH
//   AFULL_THRESH almost_full asserts when level >= AFULL_THRESH
//
// Ports
//   clk, rstn           clock (posedge) / asynchronous active-low reset
//   wr_en, wr_data      push request and data; full = no free entry
//   rd_en, rd_data      pop request and head entry (0 while empty); empty
//   err_clr             synchronous clear of the sticky error flags
//   ovf_err, udf_err    sticky push-while-full / pop-while-empty flags
//   level, almost_full  occupancy and threshold flag, only when the macro
//                       XOCC_FIFO_LEVEL_EN is defined
// ---------------------------------------------------------------------------
module xocc_cmd_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  input  logic                  err_clr,
  output logic                  ovf_err,
  output logic                  udf_err
`ifdef XOCC_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Reject configurations the pointer arithmetic cannot represent.
  generate
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8 ||
        AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_param_check
      $error("xocc_cmd_fifo: illegal ADDR_WIDTH/AFULL_THRESH");
    end
  endgenerate

  // Storage is deliberately not reset; the pointers alone define validity.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra MSB that toggles on every wrap of the address.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                push_ok;
  logic                pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // Flags come from the registered pointers, so a push into a full FIFO is
  // refused even when a pop retires an entry in the same cycle.
  assign push_ok = wr_en && !full;
  assign pop_ok  = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop_ok};
    // A new error in the clear cycle keeps the flag set.
    ovf_d = (wr_en && full)  ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    udf_d = (rd_en && empty) ? 1'b1 : (err_clr ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Gate the head word so a drained FIFO never shows a stale entry.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

`ifdef XOCC_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = AFULL_THRESH[ADDR_WIDTH:0];

  // Modulo subtraction of wrap-bit pointers gives 0..DEPTH directly.
  assign level       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (level >= AFULL_LVL);
`endif

endmodule

// File: tb/tb_xocc_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tb_xocc_cmd_fifo
//   Directed bench for xocc_cmd_fifo with a queue-based reference model.
//   A compare process checks every DUT output against the model on each
//   falling clock edge; the directed sequence adds literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xocc_cmd_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          err_clr = 1'b0;
  logic          ovf_err;
  logic          udf_err;
`ifdef XOCC_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  xocc_cmd_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .err_clr    (err_clr),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
`ifdef XOCC_FIFO_LEVEL_EN
    ,
    .level      (level),
    .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- reference model: a plain queue of words ----------------
  logic [DW-1:0] mq[$];
  bit            m_ovf = 0;
  bit            m_udf = 0;
  int            m_n;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      m_n = mq.size();
      m_ovf = (wr_en && m_n == DEPTH) ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_udf = (rd_en && m_n == 0)     ? 1'b1 : (err_clr ? 1'b0 : m_udf);
      if (rd_en && m_n > 0) void'(mq.pop_front());
      if (wr_en && m_n < DEPTH) mq.push_back(wr_data);
    end
  end

  // ---------------- per-cycle comparison against the model -----------------
  always @(negedge clk) begin
    check("cmp_empty", {31'b0, empty}, {31'b0, mq.size() == 0});
    check("cmp_full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    check("cmp_rd_data", rd_data, (mq.size() == 0) ? 32'h0 : mq[0]);
    check("cmp_ovf", {31'b0, ovf_err}, {31'b0, m_ovf});
    check("cmp_udf", {31'b0, udf_err}, {31'b0, m_udf});
`ifdef XOCC_FIFO_LEVEL_EN
    check("cmp_level", {28'b0, level}, mq.size());
    check("cmp_afull", {31'b0, almost_full}, {31'b0, mq.size() >= 6});
`endif
  end

  // One clock of stimulus; inputs change 1ns after the edge.
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re, input logic ec);
    wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    $display("cyc t=%0t we=%0d wd=%h re=%0d ec=%0d -> empty=%0d full=%0d rd=%h ovf=%0d udf=%0d",
             $time, we, wd, re, ec, empty, full, rd_data, ovf_err, udf_err);
  endtask

  logic [DW-1:0] got[$];
  int            idx;
  bit            popped_last;
  bit            we_b, re_b;

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("reset_empty", {31'b0, empty}, 32'h1);
    check("reset_full", {31'b0, full}, 32'h0);

    // Reset with the FIFO partly filled
    cyc(1, 32'h11, 0, 0);
    check("first_word_latency", rd_data, 32'h11);
    cyc(1, 32'h22, 0, 0);
    #3 rstn = 1'b0;
    #1;
    check("midrst_empty", {31'b0, empty}, 32'h1);
    check("midrst_full", {31'b0, full}, 32'h0);
    check("midrst_rd_data", rd_data, 32'h0);
    check("midrst_errs", {30'b0, ovf_err, udf_err}, 32'h0);
    @(posedge clk); #1 rstn = 1'b1;

    // Fill and overflow
    for (int i = 0; i < 8; i++) cyc(1, 32'hA0 + i, 0, 0);
    check("fill_full", {31'b0, full}, 32'h1);
    check("model_fill_size", mq.size(), 8);
    cyc(1, 32'hDEAD, 0, 0);
    check("ovf_set", {31'b0, ovf_err}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", rd_data, 32'hA0 + i);
      cyc(0, 0, 1, 0);
    end
    check("drain_empty", {31'b0, empty}, 32'h1);

    // Underflow leaves pointers alone: next push is the head
    cyc(0, 0, 1, 0);
    check("udf_set", {31'b0, udf_err}, 32'h1);
    cyc(1, 32'h55, 0, 0);
    check("udf_no_ptr_move", rd_data, 32'h55);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    check("clr_set_wins", {31'b0, udf_err}, 32'h1);
    cyc(0, 0, 0, 1);
    check("clr_flags", {30'b0, ovf_err, udf_err}, 32'h0);

    // Simultaneous push/pop at level 4
    for (int i = 0; i < 4; i++) cyc(1, 32'hB0 + i, 0, 0);
    cyc(1, 32'hB4, 1, 0);
    check("sim4_model_size", mq.size(), 4);
    for (int i = 1; i < 5; i++) begin
      check("sim4_order", rd_data, 32'hB0 + i);
      cyc(0, 0, 1, 0);
    end

    // Simultaneous push/pop at full
    for (int i = 0; i < 8; i++) cyc(1, 32'hC0 + i, 0, 0);
    cyc(1, 32'hCD, 1, 0);
    check("simfull_ovf", {31'b0, ovf_err}, 32'h1);
    check("simfull_not_full", {31'b0, full}, 32'h0);
    check("simfull_model_size", mq.size(), 7);
    for (int i = 1; i < 8; i++) begin
      check("simfull_order", rd_data, 32'hC0 + i);
      cyc(0, 0, 1, 0);
    end
    check("simfull_empty", {31'b0, empty}, 32'h1);
    cyc(0, 0, 0, 1);

    // Simultaneous push/pop at empty
    cyc(1, 32'hD0, 1, 0);
    check("simempty_udf", {31'b0, udf_err}, 32'h1);
    check("simempty_head", rd_data, 32'hD0);
    check("simempty_model_size", mq.size(), 1);
    cyc(0, 0, 1, 1);
    check("simempty_clr", {30'b0, ovf_err, udf_err}, 32'h0);

    // Wrap-around stream with the bridge consumer (never pops back-to-back)
    idx = 0; popped_last = 0;
    for (int c = 0; c < 200 && got.size() < 20; c++) begin
      we_b = (idx < 20) && !full;
      re_b = !empty && !popped_last;
      if (re_b) got.push_back(rd_data);
      cyc(we_b, 32'h100 + idx, re_b, 0);
      if (we_b) idx++;
      popped_last = re_b;
    end
    check("wrap_count", got.size(), 20);
    for (int i = 0; i < got.size(); i++) check("wrap_data", got[i], 32'h100 + i);
    check("wrap_errs", {30'b0, ovf_err, udf_err}, 32'h0);

`ifdef XOCC_FIFO_LEVEL_EN
    for (int i = 0; i < 6; i++) cyc(1, 32'hE0 + i, 0, 0);
    check("lvl6_afull", {31'b0, almost_full}, 32'h1);
    check("lvl6_level", {28'b0, level}, 32'h6);
    cyc(0, 0, 1, 0);
    check("lvl5_afull", {31'b0, almost_full}, 32'h0);
    check("lvl5_level", {28'b0, level}, 32'h5);
`endif

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
